onchip_memory_pipelined: RTL and testbench

Parametrised single-port on-chip RAM with an Avalon-MM pipelined slave interface: waitrequest, readdatavalid and a selectable read latency of 1 or 2. Adds an optional hardware zero-fill sequence after reset and explicit out-of-range address handling. Clock-enable and reset-request gating are retained. Sits on the Nios system interconnect as program/data memory or as a scratch buffer.

---
 rtl/onchip_memory_pipelined.sv | 92 +++++++++
 tb/tb_onchip_memory_pipelined.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined: Avalon-MM pipelined single-port RAM with optional post-reset zero fill
module onchip_memory_pipelined #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int DEPTH = 10240,
    parameter int READ_LATENCY = 1,
    parameter bit CLEAR_ON_RESET = 1,
    parameter INIT_FILE = "onchip_memory.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic                  chipselect,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_done
);
    localparam int NB = DATA_W / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_n;
    logic [IW-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic active, fill, in_range, wr_acc, rd_acc, wen;
    logic [IW-1:0] waddr;
    logic [DATA_W-1:0] wdata, s1_data, s2_data;
    logic [NB-1:0] wbe;
    logic s1_v, s2_v;

    assign active = clken & ~reset_req;
    assign waitrequest = (state == CLEAR) | ~active;
    assign init_done = state == READY;
    assign in_range = {1'b0, address} < DEPTH_W;
    assign wr_acc = chipselect & write & ~waitrequest;
    assign rd_acc = chipselect & read & ~write & ~waitrequest;

    always_comb begin
        state_n = state;
        fill = 1'b0;
        if (state == CLEAR && active) begin
            fill = 1'b1;
            state_n = cnt == LAST ? READY : CLEAR;
        end
    end

    always_ff @(posedge clk)
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt <= '0;
        end else if (fill) begin
            state <= state_n;
            cnt <= cnt + 1'b1;
        end

    // The fill sequence and host writes share the single write port
    assign wen = fill | (wr_acc & in_range);
    assign waddr = fill ? cnt : address[IW-1:0];
    assign wdata = fill ? '0 : writedata;
    assign wbe = fill ? '1 : byteenable;

    always_ff @(posedge clk)
        if (wen)
            for (int i = 0; i < NB; i++)
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    // Data registers only load with a valid beat so readdata holds between pulses
    always_ff @(posedge clk)
        if (reset) begin
            s1_v <= 1'b0;
            s1_data <= '0;
            s2_v <= 1'b0;
            s2_data <= '0;
        end else if (clken) begin
            s1_v <= rd_acc;
            if (rd_acc) s1_data <= in_range ? mem[address[IW-1:0]] : '0;
            s2_v <= s1_v;
            if (s1_v) s2_data <= s1_data;
        end

    assign readdata = READ_LATENCY == 2 ? s2_data : s1_data;
    assign readdatavalid = READ_LATENCY == 2 ? s2_v : s1_v;
endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// tb_onchip_memory_pipelined: latency-1 and latency-2 instances driven in lockstep, read data scoreboarded
module tb_onchip_memory_pipelined;
    logic clk = 1'b0, reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
    logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0] address = '0;
    logic [3:0] byteenable = '0;
    logic [31:0] writedata = '0;
    logic [31:0] rdata1, rdata2;
    logic rdv1, rdv2, wr1, wr2, id1, id2;
    int checks = 0, errors = 0, cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {logic [31:0] d; int due;} exp_t;
    typedef struct {bit rd; bit wr; logic [4:0] a; logic [3:0] be; logic [31:0] wd; logic [31:0] ex;} vec_t;
    exp_t q1[$], q2[$];
    vec_t vecs[$];

    onchip_memory_pipelined #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
        .address(address), .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .readdata(rdata1), .readdatavalid(rdv1), .waitrequest(wr1), .init_done(id1));

    onchip_memory_pipelined #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(chipselect),
        .address(address), .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .readdata(rdata2), .readdatavalid(rdv2), .waitrequest(wr2), .init_done(id2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, ex);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        if (q1.size() != 0 && q1[0].due == cyc) begin
            chk("rdv1", 32'(rdv1), 1);
            chk("rdata1", rdata1, q1[0].d);
            void'(q1.pop_front());
        end else chk("idle_rdv1", 32'(rdv1), 0);
        if (q2.size() != 0 && q2[0].due == cyc) begin
            chk("rdv2", 32'(rdv2), 1);
            chk("rdata2", rdata2, q2[0].d);
            void'(q2.pop_front());
        end else chk("idle_rdv2", 32'(rdv2), 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t vw(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        return '{1'b0, 1'b1, a, be, d, 32'h0};
    endfunction

    function automatic vec_t vr(input logic [4:0] a, input logic [31:0] ex);
        return '{1'b1, 1'b0, a, 4'h0, 32'h0, ex};
    endfunction

    function automatic vec_t vrw(input logic [4:0] a, input logic [31:0] d);
        return '{1'b1, 1'b1, a, 4'hf, d, 32'h0};
    endfunction

    task automatic op(input vec_t v);
        chipselect = 1'b1;
        read = v.rd;
        write = v.wr;
        address = v.a;
        byteenable = v.be;
        writedata = v.wd;
        if (v.rd && !v.wr) begin
            q1.push_back('{v.ex, cyc + 1});
            q2.push_back('{v.ex, cyc + 2});
        end
        step();
        chipselect = 1'b0;
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clken = 1'b1;
        reset_req = 1'b0;
        step();
        @(negedge clk);
        chk("rst_waitreq", 32'(wr1), 1);
        chk("rst_init_done", 32'(id1), 0);
        chk("rst_rdv", 32'(rdv1 | rdv2), 0);
        step();
        reset = 1'b0;
    endtask

    task automatic fill_check(input string nm, input int stall_at, input int stall_len);
        int total = 16 + stall_len;
        for (int k = 1; k <= total; k++) begin
            step();
            clken = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
            @(negedge clk);
            chk({nm, "_init_done"}, 32'(id1 & id2), 32'(k == total));
            chk({nm, "_waitreq"}, 32'(wr1), 32'(k != total));
        end
        step();
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;
        fill_check("fill", 0, 0);
        for (int a = 0; a < 16; a++) op(vr(5'(a), 32'h0));

        vecs.push_back(vw(5'd1, 4'hf, 32'hA1A1A1A1));
        vecs.push_back(vw(5'd2, 4'hf, 32'hB2B2B2B2));
        vecs.push_back(vw(5'd3, 4'hf, 32'hC3C3C3C3));
        vecs.push_back(vr(5'd1, 32'hA1A1A1A1));
        vecs.push_back(vr(5'd2, 32'hB2B2B2B2));
        vecs.push_back(vr(5'd3, 32'hC3C3C3C3));
        vecs.push_back(vw(5'd5, 4'hf, 32'h11223344));
        vecs.push_back(vw(5'd5, 4'b0101, 32'hDEADBEEF));
        vecs.push_back(vr(5'd5, 32'h11AD33EF));
        vecs.push_back(vw(5'd6, 4'hf, 32'h11223344));
        vecs.push_back(vw(5'd6, 4'b0110, 32'hDEADBEEF));
        vecs.push_back(vr(5'd6, 32'h11ADBE44));
        vecs.push_back(vrw(5'd20, 32'hFFFFFFFF));
        vecs.push_back(vr(5'd20, 32'h0));
        vecs.push_back(vr(5'd4, 32'h0));
        vecs.push_back(vrw(5'd7, 32'h77777777));
        vecs.push_back(vr(5'd7, 32'h77777777));
        vecs.push_back(vr(5'd3, 32'hC3C3C3C3));
        vecs.push_back(vw(5'd3, 4'hf, 32'h33333333));
        vecs.push_back(vr(5'd3, 32'h33333333));
        vecs.push_back(vw(5'd15, 4'b1000, 32'hF0ABCDEF));
        vecs.push_back(vr(5'd15, 32'hF0000000));
        vecs.push_back(vr(5'd0, 32'h0));
        foreach (vecs[i]) op(vecs[i]);
        for (int i = 0; i < 3; i++) step();

        op(vw(5'd9, 4'hf, 32'h99999999));
        op(vr(5'd9, 32'h99999999));
        reset_req = 1'b1;
        chipselect = 1'b1;
        read = 1'b1;
        address = 5'd9;
        @(negedge clk);
        chk("rreq_waitreq", 32'(wr1), 1);
        step();
        reset_req = 1'b0;
        chipselect = 1'b0;
        read = 1'b0;
        for (int i = 0; i < 4; i++) step();

        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step();
            @(negedge clk);
            chk("mid_init_done", 32'(id1), 0);
        end
        do_reset();
        fill_check("refill", 0, 0);
        op(vr(5'd1, 32'h0));
        op(vr(5'd9, 32'h0));
        for (int i = 0; i < 3; i++) step();

        do_reset();
        fill_check("stall", 7, 3);
        op(vr(5'd2, 32'h0));
        for (int i = 0; i < 4; i++) step();

        chk("queues_drained", 32'(q1.size() + q2.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
